// File: rtl/lfsr32_pkg.sv
// lfsr32_pkg: shared definitions for the 32-bit Galois LFSR (taps 32, 22, 2, 1).
// The generator and lfsr32_checker both import this package, so they use the
// same step function and seed.
//   LFSR_TAPS  - feedback mask XORed into the shifted word when s[0] is set
//   LFSR_SEED  - reset value of the checker's predictor
//   state_e    - checker FSM states HUNT / SYNC / LOCKED
//   lfsr_next  - one right-shift step of the Galois LFSR
package lfsr32_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // The bit 0 feedback goes into bit 31, and is also XORed into bits 21, 1
  // and 0 of the right-shifted word.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr32_checker.sv
// lfsr32_checker: locks onto a stream of parallel 32-bit Galois LFSR words and
// flags words that break the sequence once it is locked.
// Optional macro LFSR32_CHECKER_ERRCNT_EN adds the err_count port and a
// saturating mismatch counter behind it.
// Parameters:
//   LOCK_CNT   - consecutive correct predictions in SYNC needed to lock
//   UNLOCK_CNT - consecutive mismatches in LOCKED that drop back to HUNT
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous, active-high
//   in_valid  - in_data carries a generator word this cycle
//   in_data   - sampled LFSR state word
//   locked    - registered: checker is in LOCKED
//   err       - registered one-cycle pulse per mismatched word while LOCKED
//   err_count - saturating count of LOCKED mismatches (only with the macro)
module lfsr32_checker
  import lfsr32_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        locked,
  output logic        err
`ifdef LFSR32_CHECKER_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

  state_e         state_q, state_d;
  logic [31:0]    pred_q, pred_d;
  logic [GW-1:0]  good_cnt_q, good_cnt_d;
  logic [BW-1:0]  bad_cnt_q, bad_cnt_d;
  logic           locked_q, locked_d;
  logic           err_q, err_d;
  logic [GW-1:0]  good_inc;
  logic [BW-1:0]  bad_inc;

  assign good_inc = good_cnt_q + GW'(1);
  assign bad_inc  = bad_cnt_q + BW'(1);

  always_comb begin
    state_d    = state_q;
    pred_d     = pred_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    err_d      = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          // An all-zero word is the LFSR lockup state and cannot seed.
          if (in_data != '0) begin
            pred_d     = lfsr_next(in_data);
            good_cnt_d = '0;
            state_d    = SYNC;
          end
        end
        SYNC: begin
          if (in_data == pred_q) begin
            pred_d     = lfsr_next(in_data);
            good_cnt_d = good_inc;
            if (good_inc == GW'(LOCK_CNT)) begin
              state_d   = LOCKED;
              bad_cnt_d = '0;
            end
          end else if (in_data == '0) begin
            state_d = HUNT;
          end else begin
            pred_d     = lfsr_next(in_data);
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          // The predictor freewheels so corrupted input cannot pull it off course.
          pred_d = lfsr_next(pred_q);
          if (in_data == pred_q) begin
            bad_cnt_d = '0;
          end else begin
            err_d     = 1'b1;
            bad_cnt_d = bad_inc;
            if (bad_inc == BW'(UNLOCK_CNT)) begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      pred_q     <= LFSR_SEED;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pred_q     <= pred_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign locked = locked_q;
  assign err    = err_q;

`ifdef LFSR32_CHECKER_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr32_checker.sv
// tb_lfsr32_checker: directed self-checking bench for lfsr32_checker.
// Builds with or without LFSR32_CHECKER_ERRCNT_EN; the err_count checks and
// the saturation run exist only when the macro is defined.
module tb_lfsr32_checker;
  import lfsr32_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        locked;
  logic        err;
`ifdef LFSR32_CHECKER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] g;
  logic [15:0] exp_ec = '0;

  always #5 clk = ~clk;

  lfsr32_checker #(.LOCK_CNT(4), .UNLOCK_CNT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .locked   (locked),
    .err      (err)
`ifdef LFSR32_CHECKER_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  // Apply inputs, then sample 1 ns after the rising edge that captures them.
  task automatic cyc(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ec(input string tag);
`ifdef LFSR32_CHECKER_ERRCNT_EN
    chk(tag, {16'h0, err_count}, {16'h0, exp_ec});
`else
    if (tag.len() == 0) $display("unused");
`endif
  endtask

  // Drive the generator's current word and advance the generator.
  task automatic good_word;
    cyc(1'b1, g);
    g = lfsr_next(g);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    reset = 1'b0;
    exp_ec = '0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset_locked", {31'h0, locked}, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk_ec("reset_err_count");

    // Lock on the stream starting at the seed; hand-computed first words
    cyc(1'b1, 32'h0000_0001);
    chk("lock_w1", {30'h0, locked, err}, 32'h0);
    cyc(1'b1, 32'h8020_0003);
    chk("lock_w2", {30'h0, locked, err}, 32'h0);
    cyc(1'b1, 32'hC030_0002);
    chk("lock_w3", {30'h0, locked, err}, 32'h0);
    g = 32'h6018_0001;               // next(C0300002)
    good_word();
    chk("lock_w4", {30'h0, locked, err}, 32'h0);
    good_word();
    chk("lock_w5", {30'h0, locked, err}, 32'h2);

    // Single corrupted word (bit 0 inverted)
    cyc(1'b1, g ^ 32'h1);
    g = lfsr_next(g);
    exp_ec = 16'd1;
    chk("single_err", {30'h0, locked, err}, 32'h3);
    chk_ec("single_err_count");
    good_word();
    chk("after_single", {30'h0, locked, err}, 32'h2);
    good_word();
    chk("after_single2", {30'h0, locked, err}, 32'h2);

    // Eight consecutive bad words: locked drops with the 8th err pulse
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, g ^ 32'hFFFF_0000);
      g = lfsr_next(g);
      exp_ec++;
      chk($sformatf("unlock_bad%0d", i), {30'h0, locked, err}, (i < 8) ? 32'h3 : 32'h1);
    end
    chk_ec("unlock_err_count");
    // Relock needs 5 valid words from HUNT
    for (int i = 1; i <= 5; i++) begin
      good_word();
      chk($sformatf("relock_w%0d", i), {30'h0, locked, err}, (i < 5) ? 32'h0 : 32'h2);
    end

    // SYNC mismatch reseeds and restarts the good count
    do_reset();
    cyc(1'b1, 32'h0000_0001);
    cyc(1'b1, 32'h8020_0003);
    cyc(1'b1, 32'h1234_5678);
    chk("sync_reseed", {30'h0, locked, err}, 32'h0);
    g = lfsr_next(32'h1234_5678);
    for (int i = 1; i <= 4; i++) begin
      good_word();
      chk($sformatf("reseed_w%0d", i), {30'h0, locked, err}, (i < 4) ? 32'h0 : 32'h2);
    end

    // Gaps of invalid cycles: lock counts valid words only, never err
    do_reset();
    g = LFSR_SEED;
    for (int i = 1; i <= 5; i++) begin
      good_word();
      chk($sformatf("gap_w%0d", i), {30'h0, locked, err}, (i < 5) ? 32'h0 : 32'h2);
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        cyc(1'b0, $urandom);
        chk($sformatf("gap_idle%0d", i), {30'h0, locked, err}, (i < 5) ? 32'h0 : 32'h2);
      end
    end

    // Zero words in HUNT are ignored
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h0);
      chk("hunt_zero", {30'h0, locked, err}, 32'h0);
    end
    g = 32'hDEAD_BEEF;
    for (int i = 1; i <= 5; i++) begin
      good_word();
      chk($sformatf("zero_then_w%0d", i), {30'h0, locked, err}, (i < 5) ? 32'h0 : 32'h2);
    end

    // Reset while locked (with a pending error count) wins over in_valid
    cyc(1'b1, ~g);
    g = lfsr_next(g);
    exp_ec = 16'd1;
    chk_ec("pre_reset_err_count");
    reset = 1'b1;
    cyc(1'b1, g);
    reset = 1'b0;
    exp_ec = '0;
    chk("midreset", {30'h0, locked, err}, 32'h0);
    chk_ec("midreset_err_count");

`ifdef LFSR32_CHECKER_ERRCNT_EN
    // Saturation: 7 bad words then 1 good word keeps lock held
    g = LFSR_SEED;
    for (int i = 0; i < 5; i++) good_word();
    chk("sat_locked", {31'h0, locked}, 32'h1);
    begin
      int unsigned nbad = 0;
      int unsigned run = 0;
      while (nbad < 65540) begin
        if (run == 7) begin
          good_word();
          run = 0;
        end else begin
          cyc(1'b1, g ^ 32'h8000_0000);
          g = lfsr_next(g);
          nbad++;
          run++;
          if (nbad == 65534) begin
            exp_ec = 16'hFFFE;
            chk_ec("sat_65534");
          end
        end
      end
    end
    exp_ec = 16'hFFFF;
    chk_ec("sat_final");
    chk("sat_still_locked", {31'h0, locked}, 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
